// File: rtl/parity_lane_array_pkg.sv
// Shared types and helpers for the parity lane array: FSM states,
// beat-counter width and lane slice indexing.
package parity_lane_array_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_e;

    // Width needed to hold 0..max_beats inclusive.
    function automatic int beats_w(input int max_beats);
        return (max_beats < 1) ? 1 : $clog2(max_beats + 1);
    endfunction

    // Lowest bit index of a lane's slice inside the packed lane vector.
    function automatic int lane_lo(input int lane, input int lane_w);
        return lane * lane_w;
    endfunction

endpackage

// File: rtl/parity_lane_array_lane.sv
// Combinational per-lane beat parity: parity of the private slice XOR the
// parity of the broadcast vector, forced to 0 when the lane is disabled.
module parity_lane
    import parity_lane_array_pkg::*;
#(
    parameter int LANE_W   = 2,
    parameter int SHARED_W = 8
) (
    input  logic [LANE_W-1:0]   lane_slice,
    input  logic [SHARED_W-1:0] shared_bits,
    input  logic                lane_en,
    output logic                p
);

    assign p = lane_en & ((^lane_slice) ^ (^shared_bits));

endmodule

// File: rtl/parity_lane_array.sv
// Frame-level per-lane parity accumulator with a single-entry valid/ready
// result register. Optional per-lane masking: PARITY_LANE_ARRAY_MASK_EN.
module parity_lane_array
    import parity_lane_array_pkg::*;
#(
    parameter int LANES     = 8,
    parameter int LANE_W    = 2,
    parameter int SHARED_W  = 8,
    parameter int MAX_BEATS = 15
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          in_last,
    input  logic [SHARED_W-1:0]           shared_bits,
    input  logic [LANES*LANE_W-1:0]       lane_bits,
`ifdef PARITY_LANE_ARRAY_MASK_EN
    input  logic [LANES-1:0]              lane_mask,
`endif
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [LANES-1:0]              out_parity,
    output logic [beats_w(MAX_BEATS)-1:0] out_beats
);

    localparam int BW = beats_w(MAX_BEATS);
    localparam logic [BW-1:0] CNT_MAX = BW'(MAX_BEATS);

    logic [LANES-1:0] lane_en;
    logic [LANES-1:0] beat_p;

`ifdef PARITY_LANE_ARRAY_MASK_EN
    assign lane_en = lane_mask;
`else
    assign lane_en = '1;
`endif

    parity_lane #(
        .LANE_W   (LANE_W),
        .SHARED_W (SHARED_W)
    ) u_lane [LANES-1:0] (
        .lane_slice  (lane_bits),
        .shared_bits (shared_bits),
        .lane_en     (lane_en),
        .p           (beat_p)
    );

    state_e           state_q, state_d;
    logic [LANES-1:0] acc_q, acc_d;
    logic [BW-1:0]    cnt_q, cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [LANES-1:0] out_parity_q, out_parity_d;
    logic [BW-1:0]    out_beats_q, out_beats_d;

    logic          accept;
    logic [BW-1:0] cnt_inc;

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_valid_d  = out_valid_q;
        out_parity_d = out_parity_q;
        out_beats_d  = out_beats_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        // A last beat reloads the result register even as it drains.
        if (accept) begin
            if (in_last) begin
                out_parity_d = acc_q ^ beat_p;
                out_beats_d  = cnt_inc;
                out_valid_d  = 1'b1;
                acc_d        = '0;
                cnt_d        = '0;
                state_d      = IDLE;
            end else begin
                acc_d   = acc_q ^ beat_p;
                cnt_d   = cnt_inc;
                state_d = ACCUM;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_valid_q  <= 1'b0;
            out_parity_q <= '0;
            out_beats_q  <= '0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_valid_q  <= out_valid_d;
            out_parity_q <= out_parity_d;
            out_beats_q  <= out_beats_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_parity = out_parity_q;
    assign out_beats  = out_beats_q;

endmodule

// File: doc/parity_lane_array.md
Name: parity_lane_array

Overview:
- Parametrised, registered successor to the per-lane parity instance array.
- LANES lanes each combine a private LANE_W-bit slice with a broadcast SHARED_W-bit vector into one parity bit per beat.
- Parity is accumulated across a multi-beat frame, and one LANES-bit result per frame is presented on a valid/ready output.
- Sits between a beat-oriented data source and a checker/CSR consumer.

Parameters:
- LANES, 8, number of lanes (>=1)
- LANE_W, 2, bits per lane slice (>=1)
- SHARED_W, 8, width of the broadcast vector (>=1)
- MAX_BEATS, 15, saturation value of the beat counter (>=1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  beat offered
- in_ready  out  1  beat can be accepted
- in_last  in  1  beat closes the current frame
- shared_bits  in  SHARED_W  broadcast vector, qualified by in_valid
- lane_bits  in  LANES*LANE_W  lane i uses bits [i*LANE_W +: LANE_W]
- out_valid  out  1  frame result available
- out_ready  in  1  consumer takes the result
- out_parity  out  LANES  per-lane accumulated parity of the frame
- out_beats  out  $clog2(MAX_BEATS+1)  beats in the frame, saturating

Behaviour:
- Beat parity for lane i: p[i] = (^lane slice i) ^ (^shared_bits).
- Accept when in_valid && in_ready.
- in_ready = !out_valid || out_ready. The output register is single-entry, with no skid buffer.
- FSM states:
  - IDLE: accumulator is 0, beat count is 0.
  - ACCUM: at least one non-last beat has been accepted.
- Accepted beat with in_last=0:
  - acc <= acc ^ p; cnt <= sat(cnt+1).
  - IDLE->ACCUM, or remain in ACCUM.
- Accepted beat with in_last=1:
  - out_parity <= acc ^ p; out_beats <= sat(cnt+1); out_valid <= 1.
  - acc <= 0; cnt <= 0; next state IDLE.
  - A single-beat frame is legal and yields out_parity = p, out_beats = 1.
- Latency: result is visible on the cycle after the last beat is accepted.
- Output hold: out_parity and out_beats are stable while out_valid && !out_ready.
- out_valid clears on out_valid && out_ready, unless a new in_last beat is accepted in the same cycle. In that case the register reloads and out_valid stays 1, giving back-to-back frames at full rate.
- Non-last beats are accepted while out_valid is high only if in_ready is high. The accumulator is independent of the output register.
- Saturation: cnt stops at MAX_BEATS. Parity accumulation continues.
- Reset, including mid-frame: out_valid=0, out_parity=0, out_beats=0, acc=0, cnt=0, state IDLE. The partial frame is discarded; in_ready=1 from the first edge after release.
- in_valid=0: no state change. in_last is ignored when the beat is not accepted.

Optional Feature:
- PARITY_LANE_ARRAY_MASK_EN defined:
  - Adds input port lane_mask [LANES-1:0], sampled per accepted beat.
  - Any lane with mask bit 0 contributes p[i]=0 for that beat.
  - A lane masked on every beat of a frame reports 0.
- Undefined:
  - No lane_mask port; all lanes are always enabled.

Decomposition:
- Package parity_lane_array_pkg holds:
  - the FSM state enum (IDLE, ACCUM);
  - function beats_w(MAX_BEATS) returning the counter width;
  - a slice-index helper for lane_bits.
- Sub-module parity_lane:
  - Purely combinational, one per lane, instantiated as an instance array [LANES-1:0].
  - Inputs: LANE_W slice, SHARED_W shared vector, optional mask bit.
  - Output: p[i].
- The accumulator, counter, FSM and output register live in the top module.

Test Plan:
- Single-beat frame (defaults), shared=8'hac, lane_bits=16'hc01a, in_last=1, out_ready=1 -> next cycle out_valid=1, out_parity=8'h07, out_beats=1.
- Single-beat frame, shared=8'hca, lane_bits=16'h1f01 -> out_parity=8'h41, out_beats=1.
- Two-beat frame (8'hac/16'hc01a, then 8'hca/16'h1f01 with in_last) -> out_parity=8'h46, out_beats=2; no out_valid after the first beat.
- Back-pressure: hold out_ready=0 after a result, then offer an in_last beat -> in_ready=0, result held unchanged. Raise out_ready with the new last beat pending -> both transfer in one cycle, out_valid stays 1 with the new value.
- Saturation: 20-beat frame with shared=8'h01, lane_bits=0 -> out_beats=15, out_parity=8'h00 (even beat count). Repeat with 21 beats -> out_parity=8'hff.
- Assert rst_n low mid-frame after 3 beats, release, then send a single-beat frame 8'hac/16'hc01a -> out_parity=8'h07, out_beats=1.
- With PARITY_LANE_ARRAY_MASK_EN: lane_mask=8'hfe on the 8'hac/16'hc01a beat -> out_parity=8'h06.
